// File: rtl/clk_src_ctrl_if.sv
// Config port and clock bus of the divided-clock source controller.
interface clk_src_ctrl_if #(
  parameter int unsigned DIV_W = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_op;
  logic [4:0]       cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_err;
  logic [31:0]      clk_out;
  logic [31:0]      ch_running;

  // Requester side: test sequencer / register block and clock consumers
  modport master (
    output cfg_valid, cfg_op, cfg_ch, cfg_div,
    input  cfg_ready, cfg_err, clk_out, ch_running
  );

  // Controller side
  modport slave (
    input  cfg_valid, cfg_op, cfg_ch, cfg_div,
    output cfg_ready, cfg_err, clk_out, ch_running
  );
endinterface

// File: rtl/clk_src_ctrl.sv
// Sequences up to 32 glitch-free divided clocks; per-channel OFF/RUN/STOP control.
module clk_src_ctrl #(
  parameter int unsigned NUM_CH  = 32,
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned DIV_RST = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  clk_src_ctrl_if.slave cfg_if
);

  localparam int unsigned CH_W  = 5;
  localparam int unsigned BUS_W = 32;

  localparam logic [1:0] OP_SET_DIV = 2'b00;
  localparam logic [1:0] OP_ENABLE  = 2'b01;
  localparam logic [1:0] OP_DISABLE = 2'b10;
  localparam logic [1:0] OP_RESTART = 2'b11;

  // ST_LAST: running low phase, stop instead of the next rise
  typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_LAST, ST_STOP} ch_state_e;

  typedef struct packed {
    logic             vld;
    logic [1:0]       op;
    logic [CH_W-1:0]  ch;
    logic [DIV_W-1:0] div;
  } cfg_req_t;

  cfg_req_t         req_q, req_d;
  logic             ready_q;
  logic             err_q, err_d;

  ch_state_e        st_q   [NUM_CH];
  ch_state_e        st_d   [NUM_CH];
  logic [DIV_W-1:0] cnt_q  [NUM_CH];
  logic [DIV_W-1:0] cnt_d  [NUM_CH];
  logic [DIV_W-1:0] div_q  [NUM_CH];
  logic [DIV_W-1:0] div_d  [NUM_CH];
  logic [DIV_W-1:0] pdiv_q [NUM_CH];
  logic [DIV_W-1:0] pdiv_d [NUM_CH];
  logic [NUM_CH-1:0] pflag_q, pflag_d;
  logic [NUM_CH-1:0] out_q, out_d;
  logic [NUM_CH-1:0] run_q, run_d;

  logic [NUM_CH-1:0] ch_hit, set_v, en_v, dis_v, tc;
  logic              in_range, restart_all;

  assign cfg_if.cfg_ready  = ready_q;
  assign cfg_if.cfg_err    = err_q;
  assign cfg_if.clk_out    = BUS_W'(out_q);
  assign cfg_if.ch_running = BUS_W'(run_q);

  // Capture the accepted request and decode it for the following edge
  always_comb begin
    req_d     = '0;
    req_d.vld = cfg_if.cfg_valid && ready_q;
    req_d.op  = cfg_if.cfg_op;
    req_d.ch  = cfg_if.cfg_ch;
    req_d.div = cfg_if.cfg_div;

    ch_hit   = '0;
    set_v    = '0;
    en_v     = '0;
    dis_v    = '0;
    tc       = '0;
    in_range = 1'b0;
    restart_all = req_q.vld && (req_q.op == OP_RESTART);
    for (int c = 0; c < NUM_CH; c++) begin
      ch_hit[c] = (req_q.ch == CH_W'(c));
      set_v[c]  = req_q.vld && ch_hit[c] && (req_q.op == OP_SET_DIV);
      en_v[c]   = req_q.vld && ch_hit[c] && (req_q.op == OP_ENABLE);
      dis_v[c]  = req_q.vld && ch_hit[c] && (req_q.op == OP_DISABLE);
      tc[c]     = (cnt_q[c] == div_q[c]);
    end
    in_range = |ch_hit;
    err_d    = req_q.vld && !restart_all && !in_range;
  end

  // Handshake and request pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= '0;
    end else begin
      ready_q <= 1'b1;
      err_q   <= err_d;
      req_q   <= req_d;
    end
  end

  // Per-channel next state: counting, toggling, start/stop and divider updates
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    pdiv_d  = pdiv_q;
    pflag_d = pflag_q;
    out_d   = out_q;
    run_d   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (restart_all && (st_q[i] != ST_OFF)) begin
        // Common phase origin: restart the low phase with any pending divider
        cnt_d[i]   = '0;
        out_d[i]   = 1'b0;
        pflag_d[i] = 1'b0;
        if (pflag_q[i]) div_d[i] = pdiv_q[i];
        if (st_q[i] == ST_STOP) st_d[i] = ST_OFF;
      end else begin
        case (st_q[i])
          ST_OFF: begin
            cnt_d[i]   = '0;
            out_d[i]   = 1'b0;
            pflag_d[i] = 1'b0;
            if (pflag_q[i]) div_d[i] = pdiv_q[i];
            if (en_v[i]) st_d[i] = ST_RUN;
            if (set_v[i]) div_d[i] = req_q.div;
          end
          ST_RUN: begin
            if (tc[i]) begin
              out_d[i]   = ~out_q[i];
              cnt_d[i]   = '0;
              pflag_d[i] = 1'b0;
              if (pflag_q[i]) div_d[i] = pdiv_q[i];
            end else begin
              cnt_d[i] = cnt_q[i] + DIV_W'(1);
            end
            if (dis_v[i]) begin
              if (out_q[i]) begin
                // High phase always completes; falling at tc ends it here
                st_d[i] = tc[i] ? ST_OFF : ST_STOP;
              end else if ((cnt_q[i] == '0) || tc[i]) begin
                st_d[i]  = ST_OFF;
                out_d[i] = 1'b0;
                cnt_d[i] = '0;
              end else begin
                st_d[i] = ST_LAST;
              end
            end
          end
          ST_LAST: begin
            if (tc[i]) begin
              st_d[i]    = ST_OFF;
              cnt_d[i]   = '0;
              pflag_d[i] = 1'b0;
              if (pflag_q[i]) div_d[i] = pdiv_q[i];
            end else begin
              cnt_d[i] = cnt_q[i] + DIV_W'(1);
            end
          end
          ST_STOP: begin
            if (tc[i]) begin
              out_d[i]   = 1'b0;
              cnt_d[i]   = '0;
              pflag_d[i] = 1'b0;
              if (pflag_q[i]) div_d[i] = pdiv_q[i];
              st_d[i]    = en_v[i] ? ST_RUN : ST_OFF;
            end else begin
              cnt_d[i] = cnt_q[i] + DIV_W'(1);
              if (en_v[i]) st_d[i] = ST_RUN;
            end
          end
          default: st_d[i] = ST_OFF;
        endcase
        // Running channels take a new divider only at their next toggle
        if (set_v[i] && (st_q[i] != ST_OFF)) begin
          pdiv_d[i]  = req_q.div;
          pflag_d[i] = 1'b1;
        end
      end
      run_d[i] = (st_d[i] != ST_OFF);
    end
  end

  // Per-channel state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      run_q   <= '0;
      pflag_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]   <= ST_OFF;
        cnt_q[i]  <= '0;
        div_q[i]  <= DIV_W'(DIV_RST);
        pdiv_q[i] <= DIV_W'(DIV_RST);
      end
    end else begin
      out_q   <= out_d;
      run_q   <= run_d;
      pflag_q <= pflag_d;
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]   <= st_d[i];
        cnt_q[i]  <= cnt_d[i];
        div_q[i]  <= div_d[i];
        pdiv_q[i] <= pdiv_d[i];
      end
    end
  end

endmodule

// File: tb/tb_clk_src_ctrl.sv
// Bench for clk_src_ctrl: directed scenarios plus random traffic against a reference model.
module tb_clk_src_ctrl;
  localparam int unsigned NUM_CH = 8;
  localparam int unsigned DIV_W  = 16;

  localparam int M_OFF = 0, M_RUN = 1, M_LAST = 2, M_STOP = 3;
  localparam int OP_SET = 0, OP_EN = 1, OP_DIS = 2, OP_RST = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  clk_src_ctrl_if #(.DIV_W(DIV_W)) bus ();

  clk_src_ctrl #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DIV_RST(0)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cfg_if (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: mode, cycles left in the current phase, half period, level
  int m_mode [NUM_CH];
  int m_rem  [NUM_CH];
  int m_half [NUM_CH];
  int m_pdiv [NUM_CH];
  bit m_pflag[NUM_CH];
  bit m_lvl  [NUM_CH];
  bit m_ready, m_err;
  bit mq_vld;
  int mq_op, mq_ch, mq_div;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_mode[c] = M_OFF; m_rem[c] = 0; m_half[c] = 0; m_pdiv[c] = 0;
      m_pflag[c] = 1'b0; m_lvl[c] = 1'b0;
    end
    m_ready = 1'b0; m_err = 1'b0; mq_vld = 1'b0;
    mq_op = 0; mq_ch = 0; mq_div = 0;
  endfunction

  function automatic void take_pend(int c);
    if (m_pflag[c]) begin
      m_half[c]  = m_pdiv[c];
      m_pflag[c] = 1'b0;
    end
  endfunction

  // One controller cycle for one channel; op = -1 means no request for it
  function automatic void step_ch(int c, bit rst_all, int op, int d);
    int  mode0;
    bit  due;
    mode0 = m_mode[c];
    due   = (mode0 != M_OFF) && (m_rem[c] == 0);
    if (rst_all) begin
      if (mode0 != M_OFF) begin
        m_lvl[c] = 1'b0;
        take_pend(c);
        m_rem[c] = m_half[c];
        if (mode0 == M_STOP) m_mode[c] = M_OFF;
      end
      return;
    end
    case (mode0)
      M_OFF: begin
        take_pend(c);
        m_lvl[c] = 1'b0;
        if (op == OP_EN) begin m_mode[c] = M_RUN; m_rem[c] = m_half[c]; end
        if (op == OP_SET) begin m_half[c] = d; m_pflag[c] = 1'b0; end
      end
      M_RUN: begin
        if (op == OP_DIS) begin
          if (m_lvl[c]) begin
            if (due) begin m_lvl[c] = 1'b0; take_pend(c); m_mode[c] = M_OFF; end
            else begin m_mode[c] = M_STOP; m_rem[c]--; end
          end else if (m_rem[c] == m_half[c] || due) begin
            m_mode[c] = M_OFF;
          end else begin
            m_mode[c] = M_LAST; m_rem[c]--;
          end
        end else if (due) begin
          m_lvl[c] = !m_lvl[c]; take_pend(c); m_rem[c] = m_half[c];
        end else begin
          m_rem[c]--;
        end
      end
      M_LAST: begin
        if (due) begin m_mode[c] = M_OFF; take_pend(c); end
        else m_rem[c]--;
      end
      default: begin
        if (due) begin
          m_lvl[c] = 1'b0; take_pend(c); m_rem[c] = m_half[c];
          m_mode[c] = (op == OP_EN) ? M_RUN : M_OFF;
        end else begin
          m_rem[c]--;
          if (op == OP_EN) m_mode[c] = M_RUN;
        end
      end
    endcase
    if (op == OP_SET && mode0 != M_OFF) begin m_pdiv[c] = d; m_pflag[c] = 1'b1; end
  endfunction

  function automatic void model_step();
    bit ra;
    ra    = mq_vld && (mq_op == OP_RST);
    m_err = mq_vld && (mq_op != OP_RST) && (mq_ch >= NUM_CH);
    for (int c = 0; c < NUM_CH; c++)
      step_ch(c, ra, (mq_vld && mq_op != OP_RST && mq_ch == c) ? mq_op : -1, mq_div);
    mq_vld  = bus.cfg_valid && m_ready;
    mq_op   = int'(bus.cfg_op);
    mq_ch   = int'(bus.cfg_ch);
    mq_div  = int'(bus.cfg_div);
    m_ready = 1'b1;
  endfunction

  function automatic logic [31:0] exp_clk();
    logic [31:0] v = '0;
    for (int c = 0; c < NUM_CH; c++) v[c] = m_lvl[c];
    return v;
  endfunction

  function automatic logic [31:0] exp_run();
    logic [31:0] v = '0;
    for (int c = 0; c < NUM_CH; c++) v[c] = (m_mode[c] != M_OFF);
    return v;
  endfunction

  task automatic check_all();
    chk("clk_out", bus.clk_out, exp_clk());
    chk("ch_running", bus.ch_running, exp_run());
    chk("cfg_err", 32'(bus.cfg_err), 32'(m_err));
    chk("cfg_ready", 32'(bus.cfg_ready), 32'(m_ready));
  endtask

  // Advance one clock: model steps at the rising edge, DUT is compared at the falling edge
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(); else model_reset();
    @(negedge clk);
    check_all();
  endtask

  task automatic send(input int op, input int ch, input int div);
    bus.cfg_valid = 1'b1;
    bus.cfg_op    = 2'(op);
    bus.cfg_ch    = 5'(ch);
    bus.cfg_div   = DIV_W'(div);
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] pat;
    logic [6:0]  p3, p4;
    logic [31:0] run_before;
    bit          found, any_hi;
    int          r;

    bus.cfg_valid = 1'b0; bus.cfg_op = '0; bus.cfg_ch = '0; bus.cfg_div = '0;
    rst_n = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_clk_out", bus.clk_out, 32'h0);
    chk("rst_running", bus.ch_running, 32'h0);
    chk("rst_ready", 32'(bus.cfg_ready), 32'h0);
    chk("rst_err", 32'(bus.cfg_err), 32'h0);
    repeat (3) tick();
    rst_n = 1'b1;
    #1 chk("ready_before_edge", 32'(bus.cfg_ready), 32'h0);
    tick();
    chk("ready_after_edge", 32'(bus.cfg_ready), 32'h1);

    // ch0 div=3: low 4, high 4
    send(OP_SET, 0, 3);
    send(OP_EN, 0, 0);
    chk("ch0_run_at_accept", 32'(bus.ch_running[0]), 32'h0);
    tick();
    chk("ch0_run_next", 32'(bus.ch_running[0]), 32'h1);
    pat = '0;
    pat[0] = bus.clk_out[0];
    for (int k = 1; k < 16; k++) begin tick(); pat[k] = bus.clk_out[0]; end
    chk("ch0_pattern", 32'(pat), 32'h0000F0F0);

    // ch1 div=1: disable during high phase
    send(OP_SET, 1, 1);
    send(OP_EN, 1, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin tick(); found = bus.clk_out[1]; end
    chk("ch1_rise_found", 32'(found), 32'h1);
    send(OP_DIS, 1, 0);
    chk("ch1_high_2nd", 32'(bus.clk_out[1]), 32'h1);
    tick();
    chk("ch1_fell", 32'(bus.clk_out[1]), 32'h0);
    chk("ch1_stopped", 32'(bus.ch_running[1]), 32'h0);
    any_hi = 1'b0;
    repeat (6) begin tick(); any_hi |= bus.clk_out[1]; end
    chk("ch1_no_rise", 32'(any_hi), 32'h0);

    // ch2 div=4, shrink to 1 mid-high
    send(OP_SET, 2, 4);
    send(OP_EN, 2, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin tick(); found = bus.clk_out[2]; end
    chk("ch2_rise_found", 32'(found), 32'h1);
    pat = '0;
    pat[0] = bus.clk_out[2];
    send(OP_SET, 2, 1);
    pat[1] = bus.clk_out[2];
    for (int k = 2; k < 13; k++) begin tick(); pat[k] = bus.clk_out[2]; end
    chk("ch2_pattern", 32'(pat), 32'h0000199F);

    // ch3 div=2 and ch4 div=5, then common restart
    send(OP_SET, 3, 2);
    send(OP_EN, 3, 0);
    repeat (3) tick();
    send(OP_SET, 4, 5);
    send(OP_EN, 4, 0);
    repeat (2) tick();
    send(OP_RST, 0, 0);
    tick();
    chk("restart_low", 32'(bus.clk_out[4:3]), 32'h0);
    p3 = '0; p4 = '0;
    p3[0] = bus.clk_out[3]; p4[0] = bus.clk_out[4];
    for (int k = 1; k < 7; k++) begin tick(); p3[k] = bus.clk_out[3]; p4[k] = bus.clk_out[4]; end
    chk("ch3_after_restart", 32'(p3), 32'h38);
    chk("ch4_after_restart", 32'(p4), 32'h40);

    // Out-of-range channel
    run_before = bus.ch_running;
    send(OP_EN, 12, 0);
    tick();
    chk("err_pulse", 32'(bus.cfg_err), 32'h1);
    chk("err_running_same", bus.ch_running, run_before);
    chk("upper_bits_zero", {bus.clk_out[31:NUM_CH], bus.ch_running[31:NUM_CH]}, 32'h0);
    tick();
    chk("err_one_cycle", 32'(bus.cfg_err), 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 200; n++) begin
      r = int'($urandom_range(0, 9));
      send((r < 3) ? OP_SET : (r < 6) ? OP_EN : (r < 9) ? OP_DIS : OP_RST,
           int'($urandom_range(0, 11)), int'($urandom_range(0, 5)));
      repeat ($urandom_range(0, 4)) tick();
    end

    // Asynchronous reset during a high phase
    send(OP_DIS, 0, 0);
    repeat (16) tick();
    send(OP_SET, 0, 3);
    send(OP_EN, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin tick(); found = bus.clk_out[0]; end
    chk("ch0_high_before_rst", 32'(found), 32'h1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_clk_out", bus.clk_out, 32'h0);
    chk("async_running", bus.ch_running, 32'h0);
    chk("async_ready", 32'(bus.cfg_ready), 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    #1 chk("ready_low_after_release", 32'(bus.cfg_ready), 32'h0);
    tick();
    chk("ready_high_again", 32'(bus.cfg_ready), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/clk_src_ctrl.md
Name: clk_src_ctrl

Overview:
- Synthesizable controller that sequences up to 32 independent divided clock sources on the team's 32-bit clock bus.
- Programmed through a valid/ready config port with per-channel operations: set divider, enable, disable, plus a global phase-align restart.
- Guarantees glitch-free start/stop; no output pulse is ever shorter than its programmed half period.
- Sits between the test sequencer/register block and the clock bus consumers.

Parameters:
- NUM_CH, 32: number of channels implemented (1..32); clk_out bits at or above NUM_CH are tied 0.
- DIV_W, 16: width of the half-period divider value.
- DIV_RST, 0: divider value loaded into every channel at reset.

Ports:
- clk  in  1  controller clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  config request valid.
- cfg_ready  out  1  config request accepted when cfg_valid and cfg_ready are both high.
- cfg_op  in  2  operation: 00 SET_DIV, 01 ENABLE, 10 DISABLE, 11 RESTART_ALL.
- cfg_ch  in  5  target channel; ignored for RESTART_ALL.
- cfg_div  in  DIV_W  half-period value for SET_DIV.
- cfg_err  out  1  one-cycle pulse: accepted request targeted cfg_ch >= NUM_CH; request dropped.
- clk_out  out  32  generated clocks, registered.
- ch_running  out  32  per-channel: 1 in RUN or STOPPING.

Behaviour:
- Reset values, asserted asynchronously: clk_out=0, ch_running=0, cfg_err=0, cfg_ready=0, all channels OFF, cnt=0, div=DIV_RST, pend_div=DIV_RST, pend_flag=0.
- cfg_ready rises on the first clk edge after rst_n deasserts, then stays 1.
- Every request accepted at edge N takes effect in the registers updated at edge N+1.

Per-channel state machine (OFF / RUN / STOPPING):
- Half period is div+1 clk cycles; div=0 gives clk/2.
- OFF: out=0, cnt=0.
  - ENABLE -> RUN, cnt=0.
  - DISABLE: no-op.
- RUN: cnt increments each cycle.
  - When cnt==div: toggle out; cnt=0; if pend_flag, div<=pend_div and clear pend_flag.
  - First rising edge of out occurs div+1 cycles after entry into RUN.
- DISABLE in RUN:
  - If out=0 and cnt==0 (just fell): go to OFF.
  - If out=0 otherwise: stay RUN until the next toggle would occur, then go to OFF instead of rising.
  - If out=1: go to STOPPING.
- STOPPING: keep counting.
  - At cnt==div: out<=0, go to OFF.
  - ENABLE -> return to RUN; count continues uninterrupted.
- SET_DIV:
  - In OFF: div updates immediately.
  - In RUN or STOPPING: value goes to pend_div with pend_flag set, applied at the next toggle.
  - A second SET_DIV before that toggle overwrites pend_div.
- ENABLE in RUN: no-op.
- RESTART_ALL: every channel in RUN or STOPPING:
  - cnt<=0, out<=0, pend applied.
  - STOPPING channels go to OFF.
  - Gives a common phase origin.
- Out-of-range cfg_ch: the request is still accepted, nothing changes, and cfg_err pulses at N+1.
- ch_running is registered and reflects the state after the same edge.
- Counter wrap: cnt never exceeds div. If div shrinks below cnt via an OFF-state update, the next RUN entry resets cnt=0, so there is no wrap hazard.
- Reset mid-operation: all outputs go 0 immediately and asynchronously. The last clk_out high phase may be truncated; this is the only permitted glitch.

Test Plan:
- Reset, then SET_DIV ch0=3, ENABLE ch0:
  - clk_out[0] low 4 cycles, then high 4, period 8.
  - ch_running[0]=1 one cycle after accept.
- Run ch1 with div=1, DISABLE while clk_out[1]=1:
  - High phase completes its full 2 cycles, then low.
  - ch_running[1] drops on that falling edge; no further rise.
- Run ch2 with div=4, SET_DIV ch2=1 mid-high-phase:
  - Current phase lasts 5 cycles.
  - All subsequent phases last 2 cycles.
- Start ch3 div=2 and ch4 div=5 at different times, then RESTART_ALL:
  - Both outputs low the next cycle.
  - ch3 rises 3 cycles later, ch4 rises 6 cycles later.
- With NUM_CH=8, send ENABLE on cfg_ch=12:
  - cfg_err pulses exactly 1 cycle.
  - clk_out and ch_running are unchanged.
- Deassert rst_n mid-high-phase on running channels:
  - clk_out=0 and ch_running=0 without waiting for clk.
  - cfg_ready=0 until the first edge after release.
